// File: rtl/ysyx_040066_intr_ctrl_if.sv
// Register bus between a core-side master and the timer/interrupt block.
//
// Handshake rules for both channels:
//   - A request transfers on a rising clk edge where req_valid && req_ready.
//     While req_valid is high, the master holds req_wen/addr/wdata/wmask stable.
//   - A response transfers on a rising clk edge where rsp_valid && rsp_ready.
//     The slave holds rsp_valid/rsp_rdata/rsp_err stable until that edge.
//   - At most one request is outstanding, so req_ready is low while a
//     response is waiting.
interface ysyx_040066_intr_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_040066_intr_ctrl.sv
// Machine timer (mtime/mtimecmp) with a bus register window, plus the trap
// request logic that merges synchronous exceptions with the timer interrupt
// at instruction-retire boundaries.
module ysyx_040066_intr_ctrl #(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [63:0] BASE     = 64'h0200_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_040066_intr_ctrl_if.slave   bus,
    input  logic                     commit_valid,
    input  logic [63:0]              commit_pc,
    input  logic                     exc_valid,
    input  logic [63:0]              exc_cause,
    input  logic [63:0]              exc_tval,
    input  logic [63:0]              mie,
    input  logic [63:0]              mstatus,
    output logic                     raise_intr,
    output logic [63:0]              NO,
    output logic [63:0]              tval,
    output logic [63:0]              pc,
    output logic                     clear_mip,
    output logic                     mtip,
    output logic [1:0]               state_o
);
    localparam int unsigned   PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam logic [63:0]   ADDR_MTIME  = BASE + 64'h0000_BFF8;
    localparam logic [63:0]   ADDR_CMP    = BASE + 64'h0000_4000;
    localparam logic [63:0]   TIMER_CAUSE = 64'h8000_0000_0000_0007;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRED = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t        state_q;
    logic          clear_mip_q;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mtip_q;
    logic          rsp_valid_q, rsp_valid_d;
    logic [63:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          accept;
    logic          tick;
    logic [63:0]   bitmask;
    logic          exc_take;
    logic          timer_take;

    // Only MIE (mstatus[3]) and MTIE (mie[7]) matter here.
    logic unused_csr_bits;
    assign unused_csr_bits = ^{mie[63:8], mie[6:0], mstatus[63:4], mstatus[2:0]};

    assign bus.req_ready = ~rsp_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign clear_mip     = clear_mip_q;
    assign mtip          = mtip_q;
    assign state_o       = state_q;

    // Next-state for the prescaler, timer registers and the bus response.
    always_comb begin
        accept      = bus.req_valid & ~rsp_valid_q;
        tick        = (presc_q == PRESC_MAX);
        presc_d     = tick ? '0 : presc_q + 1'b1;
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bitmask     = '0;
        for (int i = 0; i < 8; i++) begin
            bitmask[i*8 +: 8] = {8{bus.req_wmask[i]}};
        end

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            if (bus.req_addr == ADDR_MTIME) begin
                if (bus.req_wen) begin
                    // A software write wins over this cycle's tick and restarts the prescaler.
                    mtime_d = (mtime_q & ~bitmask) | (bus.req_wdata & bitmask);
                    presc_d = '0;
                end else begin
                    rsp_rdata_d = mtime_q;
                end
            end else if (bus.req_addr == ADDR_CMP) begin
                if (bus.req_wen) begin
                    mtimecmp_d = (mtimecmp_q & ~bitmask) | (bus.req_wdata & bitmask);
                end else begin
                    rsp_rdata_d = mtimecmp_q;
                end
            end else begin
                rsp_err_d = 1'b1;
            end
        end
    end

    // Trap request: exceptions always win; the timer only fires from IDLE.
    always_comb begin
        exc_take   = commit_valid & exc_valid;
        timer_take = commit_valid & ~exc_valid & mtip_q & mstatus[3] & mie[7]
                     & (state_q == ST_IDLE);
        raise_intr = exc_take | timer_take;
        NO         = '0;
        tval       = '0;
        pc         = '0;
        if (exc_take) begin
            NO   = exc_cause;
            tval = exc_tval;
            pc   = commit_pc;
        end else if (timer_take) begin
            NO   = TIMER_CAUSE;
            pc   = commit_pc;
        end
    end

    // Timer, prescaler, pending flag and bus response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            presc_q     <= '0;
            mtip_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
            mtip_q      <= (mtime_q >= mtimecmp_q);
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Timer interrupt FSM; clear_mip is high exactly while in CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            clear_mip_q <= 1'b0;
        end else begin
            clear_mip_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (timer_take) begin
                        state_q <= ST_FIRED;
                    end
                end
                ST_FIRED: begin
                    if (!mtip_q) begin
                        state_q     <= ST_CLEAR;
                        clear_mip_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_040066_intr_ctrl.sv
// Directed bench for the timer/interrupt controller: one instance with
// TICK_DIV=1 for bus, timer and trap behaviour, one with TICK_DIV=4 for the
// prescaler and asynchronous reset.
module tb_ysyx_040066_intr_ctrl;
    localparam logic [63:0] BASE     = 64'h0200_0000;
    localparam logic [63:0] A_MTIME  = BASE + 64'h0000_BFF8;
    localparam logic [63:0] A_CMP    = BASE + 64'h0000_4000;
    localparam logic [63:0] TIMER_NO = 64'h8000_0000_0000_0007;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    // Clock and resets
    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_040066_intr_ctrl_if b1();
    ysyx_040066_intr_ctrl_if b4();

    logic        commit_valid, exc_valid;
    logic [63:0] commit_pc, exc_cause, exc_tval, mie, mstatus;
    logic        raise_intr, clear_mip, mtip;
    logic [63:0] no_o, tval_o, pc_o;
    logic [1:0]  state;

    logic        r4_raise, r4_clear, r4_mtip;
    logic [63:0] r4_no, r4_tval, r4_pc;
    logic [1:0]  r4_state;

    ysyx_040066_intr_ctrl #(.TICK_DIV(1), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .bus(b1),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mie(mie), .mstatus(mstatus),
        .raise_intr(raise_intr), .NO(no_o), .tval(tval_o), .pc(pc_o),
        .clear_mip(clear_mip), .mtip(mtip), .state_o(state)
    );

    ysyx_040066_intr_ctrl #(.TICK_DIV(4), .BASE(BASE)) dut4 (
        .clk(clk), .rst(rst4), .bus(b4),
        .commit_valid(1'b0), .commit_pc(64'd0),
        .exc_valid(1'b0), .exc_cause(64'd0), .exc_tval(64'd0),
        .mie(64'd0), .mstatus(64'd0),
        .raise_intr(r4_raise), .NO(r4_no), .tval(r4_tval), .pc(r4_pc),
        .clear_mip(r4_clear), .mtip(r4_mtip), .state_o(r4_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: one bus transfer on dut, entered and left on a falling edge.
    task automatic bus1(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
        int n;
        @(negedge clk);
        b1.req_valid = 1'b1;
        b1.req_wen   = wen;
        b1.req_addr  = addr;
        b1.req_wdata = wdata;
        b1.req_wmask = wmask;
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.req_valid = 1'b0;
        n = 0;
        while (b1.rsp_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("bus_rsp_valid", {63'd0, b1.rsp_valid}, 64'd1);
        rdata = b1.rsp_rdata;
        err   = b1.rsp_err;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;

        rst = 1'b0;
        rst4 = 1'b0;
        commit_valid = 1'b0; commit_pc = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_tval = '0;
        mie = '0; mstatus = '0;
        b1.req_valid = 1'b0; b1.req_wen = 1'b0; b1.req_addr = '0;
        b1.req_wdata = '0; b1.req_wmask = '0; b1.rsp_ready = 1'b1;
        b4.req_valid = 1'b0; b4.req_wen = 1'b0; b4.req_addr = '0;
        b4.req_wdata = '0; b4.req_wmask = '0; b4.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_mtip",      {63'd0, mtip}, 64'd0);
        chk("rst_rsp_valid", {63'd0, b1.rsp_valid}, 64'd0);
        chk("rst_rsp_err",   {63'd0, b1.rsp_err}, 64'd0);
        chk("rst_rsp_rdata", b1.rsp_rdata, 64'd0);
        chk("rst_req_ready", {63'd0, b1.req_ready}, 64'd1);
        chk("rst_clear_mip", {63'd0, clear_mip}, 64'd0);
        chk("rst_state",     {62'd0, state}, 64'd0);
        chk("rst_raise",     {63'd0, raise_intr}, 64'd0);
        chk("rst_mtime",     dut.mtime_q, 64'd0);
        chk("rst_mtimecmp",  dut.mtimecmp_q, ONES);
        chk("rst4_outputs",  {60'd0, r4_raise, r4_clear, r4_mtip, b4.rsp_valid}, 64'd0);
        rst = 1'b1;

        // Byte-masked mtime write, read back two ticks later
        bus1(1'b1, A_MTIME, 64'hAABB_CCDD_1122_3344, 8'h0F, rd, er);
        chk("wr_mtime_err", {63'd0, er}, 64'd0);
        bus1(1'b0, A_MTIME, 64'd0, 8'h00, rd, er);
        chk("rd_mtime_masked", rd, 64'h0000_0000_1122_3346);
        chk("rd_mtime_err", {63'd0, er}, 64'd0);

        // Byte-masked mtimecmp write (upper half only)
        bus1(1'b1, A_CMP, 64'h1234_5678_9ABC_DEF0, 8'hF0, rd, er);
        bus1(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
        chk("rd_cmp_masked", rd, 64'h1234_5678_FFFF_FFFF);

        // Unmapped read with the response held off for three cycles
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_wen = 1'b0; b1.req_addr = BASE + 64'h8;
        b1.rsp_ready = 1'b0;
        @(negedge clk);
        b1.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rsp_valid", {63'd0, b1.rsp_valid}, 64'd1);
            chk("hold_req_ready", {63'd0, b1.req_ready}, 64'd0);
            chk("hold_rsp_err",   {63'd0, b1.rsp_err}, 64'd1);
            chk("hold_rsp_rdata", b1.rsp_rdata, 64'd0);
            @(negedge clk);
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", {63'd0, b1.rsp_valid}, 64'd0);
        chk("hold_release_ready", {63'd0, b1.req_ready}, 64'd1);

        // Unmapped writes change nothing
        bus1(1'b1, BASE + 64'h4008, ONES, 8'hFF, rd, er);
        chk("unmapped_wr_err", {63'd0, er}, 64'd1);
        bus1(1'b1, BASE + 64'hBFF0, ONES, 8'hFF, rd, er);
        chk("unmapped_wr_err2", {63'd0, er}, 64'd1);
        bus1(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
        chk("cmp_unchanged", rd, 64'h1234_5678_FFFF_FFFF);

        // Timer interrupt: mtime=0, mtimecmp=10, commit held every cycle
        bus1(1'b1, A_MTIME, 64'd0, 8'hFF, rd, er);
        bus1(1'b1, A_CMP, 64'd10, 8'hFF, rd, er);
        mie = 64'h80;
        mstatus = 64'h8;
        commit_valid = 1'b1;
        for (int j = 0; j < 15; j++) begin
            commit_pc = 64'h8000_0000 + 64'(j) * 64'd4;
            #1;
            chk("tmr_mtip",  {63'd0, mtip}, {63'd0, (j >= 7)});
            chk("tmr_raise", {63'd0, raise_intr}, {63'd0, (j == 7)});
            if (j == 7) begin
                chk("tmr_no",    no_o, TIMER_NO);
                chk("tmr_tval",  tval_o, 64'd0);
                chk("tmr_pc",    pc_o, 64'h8000_001C);
                chk("tmr_mtime", dut.mtime_q, 64'd11);
            end else begin
                chk("tmr_no_idle", no_o, 64'd0);
            end
            @(negedge clk);
        end
        chk("tmr_state_fired", {62'd0, state}, 64'd1);

        // Clear the condition while FIRED
        bus1(1'b1, A_CMP, ONES, 8'hFF, rd, er);
        chk("clr_mtip_fell", {63'd0, mtip}, 64'd0);
        chk("clr_still_fired", {62'd0, state}, 64'd1);
        chk("clr_mip_low0", {63'd0, clear_mip}, 64'd0);
        @(negedge clk);
        chk("clr_mip_high", {63'd0, clear_mip}, 64'd1);
        chk("clr_state_clear", {62'd0, state}, 64'd2);
        chk("clr_no_raise", {63'd0, raise_intr}, 64'd0);
        @(negedge clk);
        chk("clr_mip_low1", {63'd0, clear_mip}, 64'd0);
        chk("clr_state_idle", {62'd0, state}, 64'd0);
        @(negedge clk);
        chk("clr_mip_low2", {63'd0, clear_mip}, 64'd0);

        // Exception versus timer on the same commit
        commit_valid = 1'b0;
        bus1(1'b1, A_CMP, 64'd0, 8'hFF, rd, er);
        chk("exc_mtip", {63'd0, mtip}, 64'd1);
        commit_valid = 1'b1;
        mie = 64'h0;
        #1;
        chk("mtie_off_raise", {63'd0, raise_intr}, 64'd0);
        @(negedge clk);
        mie = 64'h80;
        exc_valid = 1'b1; exc_cause = 64'd11; exc_tval = 64'h1234;
        commit_pc = 64'h8000_1000;
        #1;
        chk("exc_raise", {63'd0, raise_intr}, 64'd1);
        chk("exc_no",    no_o, 64'd11);
        chk("exc_tval",  tval_o, 64'h1234);
        chk("exc_pc",    pc_o, 64'h8000_1000);
        @(negedge clk);
        chk("exc_state_idle", {62'd0, state}, 64'd0);
        exc_valid = 1'b0;
        commit_pc = 64'h8000_1004;
        #1;
        chk("exc_next_raise", {63'd0, raise_intr}, 64'd1);
        chk("exc_next_no",    no_o, TIMER_NO);
        chk("exc_next_tval",  tval_o, 64'd0);
        chk("exc_next_pc",    pc_o, 64'h8000_1004);
        @(negedge clk);
        chk("exc_fired", {62'd0, state}, 64'd1);
        exc_valid = 1'b1; exc_cause = 64'd2; exc_tval = 64'hDEAD;
        commit_pc = 64'h8000_1008;
        #1;
        chk("exc_in_fired_raise", {63'd0, raise_intr}, 64'd1);
        chk("exc_in_fired_no",    no_o, 64'd2);
        chk("exc_in_fired_tval",  tval_o, 64'hDEAD);
        commit_valid = 1'b0;
        #1;
        chk("nocommit_raise", {63'd0, raise_intr}, 64'd0);
        chk("nocommit_outs",  no_o | tval_o | pc_o, 64'd0);
        exc_valid = 1'b0;

        // Reset while a response is pending
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_wen = 1'b1; b1.req_addr = A_CMP;
        b1.req_wdata = 64'd5; b1.req_wmask = 8'hFF; b1.rsp_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("prerst_rsp_valid", {63'd0, b1.rsp_valid}, 64'd1);
        rst = 1'b0;
        #1;
        chk("arst_rsp_valid", {63'd0, b1.rsp_valid}, 64'd0);
        chk("arst_state",     {62'd0, state}, 64'd0);
        chk("arst_mtip",      {63'd0, mtip}, 64'd0);
        chk("arst_mtime",     dut.mtime_q, 64'd0);
        chk("arst_mtimecmp",  dut.mtimecmp_q, ONES);
        @(negedge clk);
        b1.req_valid = 1'b0;
        b1.rsp_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("no_late_rsp", {63'd0, b1.rsp_valid}, 64'd0);
        bus1(1'b0, A_MTIME, 64'd0, 8'h00, rd, er);
        chk("post_rst_mtime", rd, 64'd2);
        bus1(1'b0, A_CMP, 64'd0, 8'h00, rd, er);
        chk("post_rst_cmp", rd, ONES);

        // Prescaler with TICK_DIV=4 and asynchronous reset mid-count
        @(negedge clk);
        rst4 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("div4_mtime", dut4.mtime_q, 64'(k / 4));
            chk("div4_presc", 64'(dut4.presc_q), 64'(k % 4));
        end
        #2;
        rst4 = 1'b0;
        #1;
        chk("div4_arst_mtime", dut4.mtime_q, 64'd0);
        chk("div4_arst_presc", 64'(dut4.presc_q), 64'd0);
        @(negedge clk);
        rst4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("div4_restart_mtime", dut4.mtime_q, 64'(k / 4));
            chk("div4_restart_presc", 64'(dut4.presc_q), 64'(k % 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
